// File: rtl/spi_flash_responder.sv
// spi_flash_responder: single-bit SPI mode-0 NOR flash stand-in backed by an internal byte array.
// Optional macro SPI_FLASH_QUAD_READ_EN adds the 0x6B quad-output fast read.
module spi_flash_responder #(
   parameter int ADDR_BITS   = 12,
   parameter int PROG_CYCLES = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_Clk,
   input  logic       i_nReset,
   input  logic       i_Flash_Clk,
   input  logic       i_Flash_nCS,
   input  logic       i_Flash_IO0,
   output logic [3:0] o_Flash_IO,
   output logic [3:0] o_Flash_IOEn,
   output logic       o_Busy
);
   localparam int DEPTH    = 1 << ADDR_BITS;
   localparam int SEC_BITS = (ADDR_BITS < 12) ? ADDR_BITS : 12;
   localparam int PCW      = $clog2(PROG_CYCLES + 1);
   localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(255);
   localparam logic [ADDR_BITS-1:0] SEC_MASK  = ADDR_BITS'((1 << SEC_BITS) - 1);

   typedef enum logic [3:0] {
      IDLE, OPCODE, ADDR, DATA_IN, DATA_OUT, STATUS_OUT, IGNORE
`ifdef SPI_FLASH_QUAD_READ_EN
      , DUMMY, QUAD_OUT
`endif
   } state_t;

   typedef enum logic [1:0] {CMD_READ, CMD_PROG, CMD_ERASE, CMD_QREAD} cmd_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, ncs_sync_q, io0_sync_q;
   logic                   sck_prev_q, ncs_prev_q;
   logic                   sck_s, ncs_s, io0_s, sck_rise, sck_fall, ncs_rise;

   state_t                 state_q;
   cmd_t                   cmd_q;
   logic [4:0]             bit_cnt_q;
   logic [6:0]             sh_in_q;
   logic [7:0]             sh_in_d, status_d, out_sh_q, rd_data_q;
   logic [ADDR_BITS-1:0]   addr_q, erase_base_q, mem_waddr;
   logic [SEC_BITS-1:0]    erase_off_q;
   logic [PCW-1:0]         prog_cnt_q;
   logic                   wel_q, busy_q, prog_any_q, erase_armed_q, erase_q;
   logic [3:0]             io_q, oen_q;
   logic                   prog_we, mem_we;
   logic [7:0]             mem_wdata;

   // Contents are held inverted so a zero-initialised RAM reads back as erased (0xFF) flash.
   logic [7:0]             mem_q [DEPTH];

   always_ff @(posedge i_Clk) begin
      if (!i_nReset) begin
         sck_sync_q <= '0;
         ncs_sync_q <= '1;
         io0_sync_q <= '0;
         sck_prev_q <= 1'b0;
         ncs_prev_q <= 1'b1;
      end else begin
         sck_sync_q <= SYNC_STAGES'({sck_sync_q, i_Flash_Clk});
         ncs_sync_q <= SYNC_STAGES'({ncs_sync_q, i_Flash_nCS});
         io0_sync_q <= SYNC_STAGES'({io0_sync_q, i_Flash_IO0});
         sck_prev_q <= sck_s;
         ncs_prev_q <= ncs_s;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
   assign io0_s    = io0_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q & ~ncs_s;
   assign sck_fall = ~sck_s & sck_prev_q & ~ncs_s;
   assign ncs_rise = ncs_s & ~ncs_prev_q;

   always_comb begin
      sh_in_d   = {sh_in_q, io0_s};
      status_d  = {6'b0, wel_q, busy_q};
      prog_we   = (state_q == DATA_IN) && sck_rise && (bit_cnt_q == 5'd7);
      mem_we    = i_nReset && (prog_we || erase_q);
      mem_waddr = erase_q ? (erase_base_q | ADDR_BITS'(erase_off_q)) : addr_q;
      mem_wdata = erase_q ? 8'h00 : (mem_q_inv_or(rd_data_q, sh_in_d));
   end

   function automatic logic [7:0] mem_q_inv_or(input logic [7:0] cur, input logic [7:0] data);
      return ~(cur & data);
   endfunction

   always_ff @(posedge i_Clk) begin
      if (mem_we)
         mem_q[mem_waddr] <= mem_wdata;
      rd_data_q <= ~mem_q[addr_q];
   end

   always_ff @(posedge i_Clk) begin
      if (!i_nReset) begin
         state_q       <= IDLE;
         cmd_q         <= CMD_READ;
         bit_cnt_q     <= '0;
         sh_in_q       <= '0;
         out_sh_q      <= '0;
         addr_q        <= '0;
         wel_q         <= 1'b0;
         busy_q        <= 1'b0;
         prog_cnt_q    <= '0;
         prog_any_q    <= 1'b0;
         erase_armed_q <= 1'b0;
         erase_q       <= 1'b0;
         erase_base_q  <= '0;
         erase_off_q   <= '0;
         io_q          <= '0;
         oen_q         <= '0;
      end else begin
         if (erase_q) begin
            if (erase_off_q == '1) begin
               erase_q <= 1'b0;
               busy_q  <= 1'b0;
               wel_q   <= 1'b0;
            end else begin
               erase_off_q <= erase_off_q + SEC_BITS'(1);
            end
         end else if (busy_q) begin
            if (prog_cnt_q == '0) begin
               busy_q <= 1'b0;
               wel_q  <= 1'b0;
            end else begin
               prog_cnt_q <= prog_cnt_q - PCW'(1);
            end
         end

         if (ncs_s) begin
            state_q <= IDLE;
            io_q    <= '0;
            oen_q   <= '0;
            if (ncs_rise && state_q == DATA_IN) begin
               if (prog_any_q) begin
                  busy_q     <= 1'b1;
                  prog_cnt_q <= PCW'(PROG_CYCLES - 1);
               end else begin
                  wel_q <= 1'b0;
               end
            end
            // Erase commits only if the 32nd bit was the last one seen.
            if (ncs_rise && state_q == IGNORE && erase_armed_q) begin
               erase_q      <= 1'b1;
               busy_q       <= 1'b1;
               erase_off_q  <= '0;
               erase_base_q <= addr_q & ~SEC_MASK;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  state_q       <= OPCODE;
                  bit_cnt_q     <= '0;
                  prog_any_q    <= 1'b0;
                  erase_armed_q <= 1'b0;
               end
               OPCODE: if (sck_rise) begin
                  sh_in_q   <= sh_in_d[6:0];
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_q <= '0;
                     if (busy_q && sh_in_d != 8'h05) begin
                        state_q <= IGNORE;
                     end else begin
                        case (sh_in_d)
                           8'h06: begin wel_q <= 1'b1; state_q <= IGNORE; end
                           8'h04: begin wel_q <= 1'b0; state_q <= IGNORE; end
                           8'h05: begin state_q <= STATUS_OUT; oen_q <= 4'b0010; end
                           8'h03: begin state_q <= ADDR; cmd_q <= CMD_READ; end
                           8'h02: begin state_q <= wel_q ? ADDR : IGNORE; cmd_q <= CMD_PROG; end
                           8'h20: begin state_q <= wel_q ? ADDR : IGNORE; cmd_q <= CMD_ERASE; end
`ifdef SPI_FLASH_QUAD_READ_EN
                           8'h6B: begin state_q <= ADDR; cmd_q <= CMD_QREAD; end
`endif
                           default: state_q <= IGNORE;
                        endcase
                     end
                  end
               end
               ADDR: if (sck_rise) begin
                  addr_q    <= ADDR_BITS'({addr_q, io0_s});
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_q <= '0;
                     case (cmd_q)
                        CMD_READ:  begin state_q <= DATA_OUT; oen_q <= 4'b0010; end
                        CMD_PROG:  state_q <= DATA_IN;
                        CMD_ERASE: begin state_q <= IGNORE; erase_armed_q <= 1'b1; end
`ifdef SPI_FLASH_QUAD_READ_EN
                        CMD_QREAD: state_q <= DUMMY;
`endif
                        default:   state_q <= IGNORE;
                     endcase
                  end
               end
               DATA_IN: if (sck_rise) begin
                  sh_in_q   <= sh_in_d[6:0];
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_q  <= '0;
                     prog_any_q <= 1'b1;
                     addr_q     <= (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_BITS'(1)) & PAGE_MASK);
                  end
               end
               DATA_OUT, STATUS_OUT: if (sck_fall) begin
                  bit_cnt_q <= (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd0) begin
                     if (state_q == DATA_OUT) begin
                        io_q[1]  <= rd_data_q[7];
                        out_sh_q <= {rd_data_q[6:0], 1'b0};
                        addr_q   <= addr_q + ADDR_BITS'(1);
                     end else begin
                        io_q[1]  <= status_d[7];
                        out_sh_q <= {status_d[6:0], 1'b0};
                     end
                  end else begin
                     io_q[1]  <= out_sh_q[7];
                     out_sh_q <= {out_sh_q[6:0], 1'b0};
                  end
               end
               IGNORE: if (sck_rise) erase_armed_q <= 1'b0;
`ifdef SPI_FLASH_QUAD_READ_EN
               DUMMY: if (sck_rise) begin
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_q <= '0;
                     state_q   <= QUAD_OUT;
                     oen_q     <= 4'b1111;
                  end
               end
               QUAD_OUT: if (sck_fall) begin
                  if (bit_cnt_q[0] == 1'b0) begin
                     io_q      <= rd_data_q[7:4];
                     out_sh_q  <= rd_data_q;
                     addr_q    <= addr_q + ADDR_BITS'(1);
                     bit_cnt_q <= 5'd1;
                  end else begin
                     io_q      <= out_sh_q[3:0];
                     bit_cnt_q <= 5'd0;
                  end
               end
`endif
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign o_Flash_IO   = io_q;
   assign o_Flash_IOEn = oen_q;
   assign o_Busy       = busy_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives SPI mode-0 transactions and checks status, program, erase and wrap behaviour.
module tb_spi_flash_responder;
   localparam int HALF = 5;
   localparam int PROG = 160;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       sck = 1'b0;
   logic       ncs = 1'b1;
   logic       io0 = 1'b0;
   logic [3:0] f_io, f_ioen;
   logic       busy;

   int tests = 0;
   int failures = 0;
   int busy_run = 0;
   int last_busy_len = 0;

   logic [7:0] rx_buf [8];
   logic [3:0] oen_buf [8];
   logic [7:0] st;
   logic [3:0] st_oen;

   spi_flash_responder #(
      .ADDR_BITS   (12),
      .PROG_CYCLES (PROG),
      .SYNC_STAGES (2)
   ) dut (
      .i_Clk        (clk),
      .i_nReset     (nreset),
      .i_Flash_Clk  (sck),
      .i_Flash_nCS  (ncs),
      .i_Flash_IO0  (io0),
      .o_Flash_IO   (f_io),
      .o_Flash_IOEn (f_ioen),
      .o_Busy       (busy)
   );

   always #5 clk = ~clk;

   // Length of the most recent completed BUSY pulse, in i_Clk cycles.
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         busy_run <= busy_run + 1;
      end else if (busy_run != 0) begin
         last_busy_len <= busy_run;
         busy_run      <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic [3:0] oen_mid);
      rx = '0;
      oen_mid = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         io0 = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = f_io[1];
         if (i == 4) oen_mid = f_ioen;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic put(input logic [7:0] b);
      logic [7:0] d;
      logic [3:0] e;
      spi_bits(b, 8, d, e);
   endtask

   task automatic get(output logic [7:0] b, output logic [3:0] oen);
      spi_bits(8'h00, 8, b, oen);
   endtask

   task automatic begin_txn();
      ncs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic end_txn(input string name);
      repeat (2) @(negedge clk);
      ncs = 1'b1;
      repeat (8) @(negedge clk);
      $display("[TB] txn %s", name);
   endtask

   task automatic simple(input logic [7:0] op, input string name);
      begin_txn();
      put(op);
      end_txn(name);
   endtask

   task automatic rdsr(output logic [7:0] s, output logic [3:0] oen);
      begin_txn();
      put(8'h05);
      get(s, oen);
      end_txn("RDSR");
   endtask

   task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
      put(op);
      put(a[23:16]);
      put(a[15:8]);
      put(a[7:0]);
   endtask

   task automatic read_mem(input logic [23:0] a, input int n);
      begin_txn();
      cmd_addr(8'h03, a);
      for (int i = 0; i < n; i++) get(rx_buf[i], oen_buf[i]);
      end_txn($sformatf("READ 0x%06h x%0d", a, n));
   endtask

   task automatic wait_idle(input int limit);
      for (int k = 0; k < limit; k++) begin
         if (busy === 1'b0) break;
         @(negedge clk);
      end
      @(negedge clk);
      check("busy_wait", {31'b0, busy}, 32'h0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("rst_io", {28'b0, f_io}, 32'h0);
      check("rst_ioen", {28'b0, f_ioen}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      nreset = 1'b1;
      repeat (4) @(negedge clk);

      // Status after reset, output enable only during the data byte
      rdsr(st, st_oen);
      check("rdsr_reset", {24'b0, st}, 32'h00);
      check("rdsr_oen_data", {28'b0, st_oen}, 32'h2);
      check("rdsr_oen_after", {28'b0, f_ioen}, 32'h0);

      simple(8'h06, "WREN");
      rdsr(st, st_oen);
      check("rdsr_wel", {24'b0, st}, 32'h02);
      simple(8'h04, "WRDI");
      rdsr(st, st_oen);
      check("rdsr_wrdi", {24'b0, st}, 32'h00);

      // Page program then immediate status poll
      simple(8'h06, "WREN");
      begin_txn();
      cmd_addr(8'h02, 24'h000010);
      put(8'hA5);
      put(8'h3C);
      end_txn("PP 0x000010 A5 3C");
      rdsr(st, st_oen);
      check("rdsr_prog_busy", {24'b0, st}, 32'h03);
      wait_idle(PROG + 50);
      check("prog_busy_len", last_busy_len, PROG);
      rdsr(st, st_oen);
      check("rdsr_prog_done", {24'b0, st}, 32'h00);

      read_mem(24'h000010, 3);
      check("rd_10", {24'b0, rx_buf[0]}, 32'hA5);
      check("rd_11", {24'b0, rx_buf[1]}, 32'h3C);
      check("rd_12", {24'b0, rx_buf[2]}, 32'hFF);
      check("rd_oen", {28'b0, oen_buf[1]}, 32'h2);

      // Program without WREN is ignored
      begin_txn();
      cmd_addr(8'h02, 24'h000020);
      put(8'h55);
      end_txn("PP no WREN 0x000020 55");
      check("nowren_busy", {31'b0, busy}, 32'h0);
      read_mem(24'h000020, 1);
      check("rd_20", {24'b0, rx_buf[0]}, 32'hFF);

      // Programming only clears bits
      simple(8'h06, "WREN");
      begin_txn();
      cmd_addr(8'h02, 24'h000010);
      put(8'h0F);
      end_txn("PP 0x000010 0F");
      wait_idle(PROG + 50);
      read_mem(24'h000010, 1);
      check("rd_and", {24'b0, rx_buf[0]}, 32'h05);

      // Sector erase, with a read attempted while BUSY
      simple(8'h06, "WREN");
      begin_txn();
      cmd_addr(8'h20, 24'h000000);
      end_txn("SE 0x000000");
      check("erase_busy", {31'b0, busy}, 32'h1);
      read_mem(24'h000010, 1);
      check("busy_read_oen", {28'b0, oen_buf[0]}, 32'h0);
      check("busy_read_io", {28'b0, f_io}, 32'h0);
      wait_idle(5000);
      check("erase_busy_len", last_busy_len, 4096);
      read_mem(24'h000010, 2);
      check("erase_rd_10", {24'b0, rx_buf[0]}, 32'hFF);
      check("erase_rd_11", {24'b0, rx_buf[1]}, 32'hFF);
      rdsr(st, st_oen);
      check("rdsr_erase_done", {24'b0, st}, 32'h00);

      // Page wrap on program, array wrap on read, modulo addressing
      simple(8'h06, "WREN");
      begin_txn();
      cmd_addr(8'h02, 24'h000FFF);
      put(8'h12);
      put(8'h34);
      end_txn("PP 0x000FFF 12 34");
      wait_idle(PROG + 50);
      simple(8'h06, "WREN");
      begin_txn();
      cmd_addr(8'h02, 24'h000000);
      put(8'h5A);
      end_txn("PP 0x000000 5A");
      wait_idle(PROG + 50);
      read_mem(24'hABCFFF, 2);
      check("wrap_fff", {24'b0, rx_buf[0]}, 32'h12);
      check("wrap_000", {24'b0, rx_buf[1]}, 32'h5A);
      read_mem(24'h000F00, 1);
      check("page_wrap_f00", {24'b0, rx_buf[0]}, 32'h34);

      // Partial opcode is discarded
      begin_txn();
      spi_bits(8'h06, 5, st, st_oen);
      end_txn("WREN 5 bits");
      rdsr(st, st_oen);
      check("partial_wren", {24'b0, st}, 32'h00);

      // Erase with more than 32 bits does nothing
      simple(8'h06, "WREN");
      begin_txn();
      cmd_addr(8'h20, 24'h000000);
      put(8'h00);
      end_txn("SE 33+ bits");
      check("erase33_busy", {31'b0, busy}, 32'h0);
      rdsr(st, st_oen);
      check("erase33_status", {24'b0, st}, 32'h02);
      read_mem(24'h000000, 1);
      check("erase33_mem", {24'b0, rx_buf[0]}, 32'h5A);

      // Reset in the middle of an erase
      begin_txn();
      cmd_addr(8'h20, 24'h000000);
      end_txn("SE 0x000000");
      repeat (100) @(negedge clk);
      check("mid_erase_busy", {31'b0, busy}, 32'h1);
      nreset = 1'b0;
      @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_ioen", {28'b0, f_ioen}, 32'h0);
      nreset = 1'b1;
      repeat (4) @(negedge clk);
      $display("[TB] txn RESET mid-erase");
      rdsr(st, st_oen);
      check("rdsr_after_reset", {24'b0, st}, 32'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
